// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for the round-robin arbitrated mux (rr_arb_mux).
// sel_width() sizes the source-index field; rr_next() is the pointer wrap rule
// used by the arbiter after every accepted beat.
package mux_pkg;

    // Width of a channel index: never narrower than one bit, even for a single channel.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Position just past the granted channel, wrapping at the last channel.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// Round-robin arbiter for rr_arb_mux.
// The search starts at the priority pointer and wraps, so the channel that was
// just served has the lowest priority on the next decision. The pointer only
// advances when the granted beat is actually taken (en), which bounds the wait
// of any requester to N_IN-1 grants to other channels.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int SEL_W = sel_width(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  req,
    input  logic             en,
    output logic [N_IN-1:0]  grant,
    output logic [SEL_W-1:0] gidx
);

    logic [SEL_W-1:0] r_ptr;
    int               w_idx;
    logic             w_found;

    // First requesting channel at or after r_ptr, wrapping past N_IN-1.
    always_comb begin
        grant   = '0;
        gidx    = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N_IN; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_IN) begin
                w_idx = w_idx - N_IN;
            end
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                gidx         = SEL_W'(w_idx);
            end
        end
    end

    // Priority pointer moves just past the channel whose beat was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= SEL_W'(rr_next(int'(gidx), N_IN));
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-way valid/ready multiplexer with round-robin arbitration and a registered
// output carrying the index of the source channel.
// Build option: define RR_ARB_MUX_SKID_EN to add a one-entry skid register that
// removes the combinational out_ready -> in_ready path. Without it, an output
// beat that drains in the same cycle is replaced by the newly accepted one.
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  N_IN       = 4,
    localparam int SEL_W      = sel_width(N_IN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_IN*DATA_WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]            in_valid,
    output logic [N_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]           out_sel,
    output logic                       out_valid,
    input  logic                       out_ready
);

    logic [DATA_WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0]      r_out_sel;
    logic                  r_out_valid;

    logic [N_IN-1:0]       w_grant;
    logic [SEL_W-1:0]      w_gidx;
    logic                  w_load_en;
    logic [N_IN-1:0]       w_in_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_in_beat;

    rr_arbiter #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_arbiter (
        .clk   (clk),
        .rst   (rst),
        .req   (in_valid),
        .en    (w_accept),
        .grant (w_grant),
        .gidx  (w_gidx)
    );

    // Output register may take a new beat when it is empty or being drained now.
    assign w_load_en = ~r_out_valid | out_ready;
    assign w_in_beat = in_data[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
    // The grant only exists for a valid channel, so any ready bit means a transfer.
    assign w_accept  = |(w_in_ready & in_valid);

`ifdef RR_ARB_MUX_SKID_EN

    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [SEL_W-1:0]      r_skid_sel;
    logic                  r_skid_valid;

    // Ready depends only on skid occupancy, never on out_ready; forced low in reset.
    assign w_in_ready = w_grant & {N_IN{~r_skid_valid & ~rst}};

    // Skid holds a beat accepted while the output stalls; it always drains first to keep order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_sel    <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_sel   <= '0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            if (out_ready) begin
                r_out_data   <= r_skid_data;
                r_out_sel    <= r_skid_sel;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (w_load_en) begin
                r_out_data  <= w_in_beat;
                r_out_sel   <= w_gidx;
                r_out_valid <= 1'b1;
            end else begin
                r_skid_data  <= w_in_beat;
                r_skid_sel   <= w_gidx;
                r_skid_valid <= 1'b1;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`else

    // Ready follows the output stage directly; forced low while reset is asserted.
    assign w_in_ready = w_grant & {N_IN{w_load_en & ~rst}};

    // A new beat overwrites the output register, including one draining this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_data  <= w_in_beat;
            r_out_sel   <= w_gidx;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`endif

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule
